// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: widths, default
// constants, FSM state encoding and the jalr target helper.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_ERR
  } fetch_state_t;

  // jalr semantics: bit 0 of the target is dropped without complaint
  function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] target);
    return {target[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selection applied on retirement: sequential pc+4 or a redirect
// target, plus a flag for a target that is not word aligned.
module pc_next_sel
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  always_comb begin
    next_pc    = pc + 32'd4;
    misaligned = 1'b0;
    if (redirect) begin
      next_pc    = jalr_target(redirect_pc);
      misaligned = redirect_pc[1];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one word per instruction over a
// valid/ready channel and holds it for the decoder until execute retires it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  fetch_state_t state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] next_pc;
  logic        misaligned;
  logic        pc_load;
  logic        rsp_capture;

  pc_next_sel u_pc_next_sel (
    .pc          (pc_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  // ERR is terminal; only reset leaves it
  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    rsp_capture = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d     = ST_HOLD;
          rsp_capture = 1'b1;
        end
      end
      ST_HOLD: begin
        if (inst_ack) begin
          if (misaligned) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_REQ;
            pc_load = 1'b1;
          end
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
    end else begin
      if (pc_load) pc_q <= next_pc;
      if (rsp_capture) begin
        inst_q    <= imem_rsp_data;
        inst_pc_q <= pc_q;
      end
    end
  end

  // Outputs decode from registered state only, never from inputs
  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == ST_HOLD);
  assign inst           = inst_valid ? inst_q : NOP_INST;
  assign inst_pc        = inst_pc_q;
  assign fetch_err      = (state_q == ST_ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a program-order PC model feeds
// expected request/instruction queues that a negedge monitor drains.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ack;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ack       (inst_ack),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] expReqQ[$];
  logic [31:0] expPcQ[$];
  logic [31:0] expInstQ[$];

  logic [31:0] modelPc;
  bit          expErr;
  bit          errArm;

  bit          pend;
  int          lat;
  logic [31:0] paddr;

  int readyPct, maxLat, spurPct, ackPct, redirPct;
  bit randAck, holdRedirect;
  bit ackOnce, onceRedir;
  logic [31:0] onceRp;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    int r;
    t = $urandom;
    r = int'($urandom_range(99, 0));
    if (r < 3)       t[1] = 1'b1;
    else if (r < 12) t = {30'h3FFF_FFFF, 1'b0, t[0]};
    else             t[1] = 1'b0;
    return t;
  endfunction

  // Program-order model: every fetch the core should make, in order
  task automatic expectFetch(input logic [31:0] pc);
    expReqQ.push_back(pc);
    expPcQ.push_back(pc);
    expInstQ.push_back(memWord(pc));
  endtask

  task automatic modelRetire(input bit redir, input logic [31:0] rp);
    if (redir && rp[1]) begin
      errArm = 1'b1;
    end else begin
      modelPc = redir ? {rp[31:1], 1'b0} : modelPc + 32'd4;
      expectFetch(modelPc);
    end
  endtask

  // Decide inputs for the coming edge from outputs sampled just after the last one
  task automatic applyStimulus();
    if (errArm) begin
      expErr = 1'b1;
      errArm = 1'b0;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend) begin
      if (lat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memWord(paddr);
        pend           = 1'b0;
      end else begin
        lat--;
      end
    end else if (pct(spurPct)) begin
      imem_rsp_valid = 1'b1;
    end
    imem_req_ready = 1'b0;
    if (imem_req_valid) begin
      if (pct(readyPct)) begin
        imem_req_ready = 1'b1;
        pend  = 1'b1;
        lat   = int'($urandom_range(unsigned'(maxLat), 0));
        paddr = imem_req_addr;
      end
    end else begin
      imem_req_ready = pct(spurPct);
    end
    inst_ack    = 1'b0;
    redirect    = holdRedirect ? 1'b1 : pct(50);
    redirect_pc = holdRedirect ? 32'h0000_0040 : randTarget();
    if (inst_valid && !expErr) begin
      if (ackOnce) begin
        inst_ack    = 1'b1;
        redirect    = onceRedir;
        redirect_pc = onceRp;
        ackOnce     = 1'b0;
      end else if (randAck && pct(ackPct)) begin
        inst_ack = 1'b1;
        redirect = pct(redirPct);
      end
      if (inst_ack) modelRetire(redirect, redirect_pc);
    end else if (randAck) begin
      inst_ack = pct(10);
    end
  endtask

  task automatic step();
    applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    inst_ack       = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h0000_0100;
    pend = 1'b0; errArm = 1'b0; expErr = 1'b0; ackOnce = 1'b0;
    expReqQ.delete();
    expPcQ.delete();
    expInstQ.delete();
    modelPc = RESET_PC;
    expectFetch(modelPc);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
    checkOutput("rst_inst", inst, NOP);
    checkOutput("rst_inst_pc", inst_pc, RESET_PC);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_fetch_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic waitValid(input int budget, output int n);
    n = 0;
    while (!inst_valid && n < budget) begin
      step();
      n++;
    end
    if (!inst_valid) checkOutput("inst_valid_timeout", 32'(inst_valid), 32'd1);
  endtask

  task automatic retireOnce(input bit redir, input logic [31:0] rp);
    ackOnce   = 1'b1;
    onceRedir = redir;
    onceRp    = rp;
    step();
  endtask

  // Monitor: compares every request and every newly presented instruction
  bit seen;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (imem_req_valid) begin
        if (expReqQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL req_unexpected: got addr %h, expected no request", imem_req_addr);
        end else begin
          checkOutput("req_addr", imem_req_addr, expReqQ[0]);
          if (imem_req_ready) void'(expReqQ.pop_front());
        end
      end
      checkOutput("fetch_err", 32'(fetch_err), 32'(expErr));
      if (expErr) begin
        checkOutput("err_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("err_inst_valid", 32'(inst_valid), 32'd0);
      end
      if (inst_valid) begin
        if (!seen) begin
          if (expPcQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL inst_unexpected: got pc %h inst %h, expected none", inst_pc, inst);
          end else begin
            checkOutput("inst_pc", inst_pc, expPcQ.pop_front());
            checkOutput("inst", inst, expInstQ.pop_front());
          end
          seen = 1'b1;
        end
      end else begin
        checkOutput("inst_nop", inst, NOP);
      end
      if (!inst_valid || inst_ack) seen = 1'b0;
    end
  end

  initial begin
    int n;
    int errCycles;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    inst_ack = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    readyPct = 100; maxLat = 0; spurPct = 0; ackPct = 0; redirPct = 0;
    randAck = 1'b0; holdRedirect = 1'b0; ackOnce = 1'b0;
    lat = 0; paddr = 32'h0; onceRedir = 1'b0; onceRp = 32'h0;

    doReset();
    checkOutput("idle_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("first_req_addr", imem_req_addr, RESET_PC);
    step();
    checkOutput("wait_inst_valid", 32'(inst_valid), 32'd0);
    step();
    checkOutput("first_inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("first_inst", inst, 32'h0050_0093);
    checkOutput("first_inst_pc", inst_pc, 32'h0);

    for (int i = 0; i < 3; i++) begin
      retireOnce(1'b0, 32'h0);
      if (i == 1) begin
        readyPct = 0;
        repeat (3) step();
        readyPct = 100;
        waitValid(20, n);
      end else begin
        waitValid(20, n);
        checkOutput("ack_to_valid", 32'(n + 1), 32'd3);
      end
    end
    checkOutput("seq_inst_pc", inst_pc, 32'h0000_000C);

    retireOnce(1'b1, 32'h0000_0101);
    waitValid(20, n);
    checkOutput("redir_inst_pc", inst_pc, 32'h0000_0100);

    retireOnce(1'b1, 32'hFFFF_FFFC);
    waitValid(20, n);
    holdRedirect = 1'b1;
    repeat (3) step();
    holdRedirect = 1'b0;
    checkOutput("noack_inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("noack_inst_pc", inst_pc, 32'hFFFF_FFFC);
    retireOnce(1'b0, 32'h0);
    waitValid(20, n);
    checkOutput("wrap_inst_pc", inst_pc, 32'h0000_0000);

    retireOnce(1'b1, 32'h0000_0102);
    repeat (6) step();
    checkOutput("err_flag", 32'(fetch_err), 32'd1);
    checkOutput("err_inst", inst, NOP);

    doReset();
    step();
    step();
    doReset();
    spurPct = 100; readyPct = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("spur_inst_valid", 32'(inst_valid), 32'd0);
    end
    checkOutput("spur_req_addr", imem_req_addr, RESET_PC);
    spurPct = 0; readyPct = 100;
    waitValid(20, n);
    checkOutput("after_wait_rst_pc", inst_pc, RESET_PC);

    randAck = 1'b1;
    errCycles = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        readyPct = int'($urandom_range(100, 30));
        maxLat   = int'($urandom_range(3, 0));
        spurPct  = int'($urandom_range(40, 0));
        ackPct   = int'($urandom_range(90, 20));
        redirPct = int'($urandom_range(60, 0));
      end
      errCycles = expErr ? errCycles + 1 : 0;
      if (errCycles > 8 || pct(1)) begin
        doReset();
        errCycles = 0;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
